// File: rtl/count16_sched_pkg.sv
// Shared types and default sizes for the count16_sched sequencing controller.
package count16_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/count16_sched_if.sv
// Command/status bundle between a host (master) and the count16_sched controller (slave).
interface count16_sched_if
  import count16_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
);

  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] load_val;
  logic [DIV_W-1:0] div;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             paused;
  logic             done;

  modport master (
    output start, stop, pause, load_val, div, auto_reload,
    input  out, busy, paused, done
  );

  modport slave (
    input  start, stop, pause, load_val, div, auto_reload,
    output out, busy, paused, done
  );

endinterface

// File: rtl/count16_ld.sv
// Loadable up-counter with synchronous clear/enable and a terminal-count compare flag.
module count16_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             at_term
);

  // Clear takes priority so a restart always lands on zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

  assign at_term = (q == term);

endmodule

// File: rtl/count16_sched.sv
// Start/stop/pause sequencer around count16_ld with prescaler, terminal count and auto-reload.
module count16_sched
  import count16_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input logic           clk,
  input logic           reset,
  count16_sched_if.slave bus
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, div_q;
  logic [WIDTH-1:0] term_q, cnt;
  logic             auto_q, done_q;
  logic             at_term, run_ok, tick, term_hit;
  logic             do_start, do_stop;
  logic             cnt_clr, cnt_en, presc_clr, presc_inc;
  logic             busy, paused;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.pause)                state_d = PAUSE;
          else if (term_hit && !auto_q) state_d = IDLE;
        end
        PAUSE: if (!bus.pause) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // A tick is only processed on an edge with no stop, start or pause pending.
  always_comb begin
    busy      = (state_q == RUN) || (state_q == PAUSE);
    paused    = (state_q == PAUSE);
    do_stop   = bus.stop && busy;
    do_start  = bus.start && !bus.stop;
    run_ok    = (state_q == RUN) && !bus.stop && !bus.start && !bus.pause;
    tick      = run_ok && (presc_q == div_q);
    term_hit  = tick && at_term;
    cnt_clr   = do_start || do_stop || (term_hit && auto_q);
    cnt_en    = tick && !at_term;
    presc_clr = do_start || do_stop || tick;
    presc_inc = run_ok && !tick;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      term_q  <= '0;
      div_q   <= '0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= term_hit;
      if (do_start) begin
        term_q <= bus.load_val;
        div_q  <= bus.div;
        auto_q <= bus.auto_reload;
      end
      if (presc_clr) begin
        presc_q <= '0;
      end else if (presc_inc) begin
        presc_q <= presc_q + DIV_W'(1);
      end
    end
  end

  count16_ld #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (term_q),
    .q       (cnt),
    .at_term (at_term)
  );

  assign bus.out    = cnt;
  assign bus.busy   = busy;
  assign bus.paused = paused;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_count16_sched.sv
// Directed self-checking bench for count16_sched: vector table plus hand-written corner sequences.
module tb_count16_sched;
  import count16_sched_pkg::*;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       pause;
    logic [3:0] lv;
    logic [3:0] dv;
    logic       ar;
    logic [3:0] e_out;
    logic       e_busy;
    logic       e_paused;
    logic       e_done;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  count16_sched_if #(.WIDTH(4), .DIV_W(4)) bus ();

  count16_sched #(.WIDTH(4), .DIV_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's worth of inputs, then drop the pulse commands after the edge.
  task automatic applyStimulus(input logic s, input logic p, input logic ps,
                               input logic [3:0] lv, input logic [3:0] dv, input logic ar);
    bus.start       = s;
    bus.stop        = p;
    bus.pause       = ps;
    bus.load_val    = lv;
    bus.div         = dv;
    bus.auto_reload = ar;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eo,
                             input logic eb, input logic ep, input logic ed);
    checks++;
    if (bus.out !== eo) begin
      errors++;
      $display("[TB] FAIL %s.out got %0d expected %0d", name, bus.out, eo);
    end
    checks++;
    if (bus.busy !== eb) begin
      errors++;
      $display("[TB] FAIL %s.busy got %b expected %b", name, bus.busy, eb);
    end
    checks++;
    if (bus.paused !== ep) begin
      errors++;
      $display("[TB] FAIL %s.paused got %b expected %b", name, bus.paused, ep);
    end
    checks++;
    if (bus.done !== ed) begin
      errors++;
      $display("[TB] FAIL %s.done got %b expected %b", name, bus.done, ed);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.load_val = '0; bus.div = '0; bus.auto_reload = 1'b0;

    // Reset held for two edges with a start pending, which must be ignored.
    reset = 1'b0;
    applyStimulus(1, 0, 0, 4'd5, 4'd0, 0);
    applyStimulus(1, 0, 0, 4'd5, 4'd0, 0);
    checkOutput("reset", 4'd0, 0, 0, 0);
    reset = 1'b1;

    vecs.push_back('{"os_start",   1, 0, 0, 4'd5, 4'd0, 0, 4'd0, 1, 0, 0});
    vecs.push_back('{"os_n1",      0, 0, 0, 4'd9, 4'd7, 1, 4'd1, 1, 0, 0});
    vecs.push_back('{"os_n2",      0, 0, 0, 4'd9, 4'd7, 1, 4'd2, 1, 0, 0});
    vecs.push_back('{"os_n3",      0, 0, 0, 4'd0, 4'd0, 0, 4'd3, 1, 0, 0});
    vecs.push_back('{"os_n4",      0, 0, 0, 4'd0, 4'd0, 0, 4'd4, 1, 0, 0});
    vecs.push_back('{"os_n5",      0, 0, 0, 4'd0, 4'd0, 0, 4'd5, 1, 0, 0});
    vecs.push_back('{"os_done",    0, 0, 0, 4'd0, 4'd0, 0, 4'd5, 0, 0, 1});
    vecs.push_back('{"os_hold",    0, 0, 0, 4'd0, 4'd0, 0, 4'd5, 0, 0, 0});
    vecs.push_back('{"idle_pause", 0, 0, 1, 4'd0, 4'd0, 0, 4'd5, 0, 0, 0});
    vecs.push_back('{"lv0_start",  1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 0, 0});
    vecs.push_back('{"lv0_done",   0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1});
    vecs.push_back('{"lv0_after",  0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].pause,
                    vecs[i].lv, vecs[i].dv, vecs[i].ar);
      checkOutput(vecs[i].name, vecs[i].e_out, vecs[i].e_busy,
                  vecs[i].e_paused, vecs[i].e_done);
    end
    bus.pause = 1'b0;

    // Auto-reload, div=2: step every 3 clocks, done every 12; div changes mid-run are ignored.
    applyStimulus(1, 0, 0, 4'd3, 4'd2, 1);
    checkOutput("auto_start", 4'd0, 1, 0, 0);
    for (int c = 1; c <= 26; c++) begin
      applyStimulus(0, 0, 0, 4'd3, 4'd0, 0);
      checkOutput($sformatf("auto_c%0d", c), 4'((c / 3) % 4), 1, 0, (c % 12) == 0);
    end
    applyStimulus(0, 1, 0, 4'd3, 4'd0, 0);
    checkOutput("auto_stop", 4'd0, 0, 0, 0);

    // Pause for four edges at out=7 during a full-range count.
    applyStimulus(1, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("pz_start", 4'd0, 1, 0, 0);
    for (int n = 1; n <= 7; n++) begin
      applyStimulus(0, 0, 0, 4'd15, 4'd0, 0);
      checkOutput($sformatf("pz_n%0d", n), 4'(n), 1, 0, 0);
    end
    for (int n = 0; n < 4; n++) begin
      applyStimulus(0, 0, 1, 4'd15, 4'd0, 0);
      checkOutput($sformatf("pz_hold%0d", n), 4'd7, 1, 1, 0);
    end
    applyStimulus(0, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("pz_resume", 4'd7, 1, 0, 0);
    for (int n = 8; n <= 15; n++) begin
      applyStimulus(0, 0, 0, 4'd15, 4'd0, 0);
      checkOutput($sformatf("pz_n%0d", n), 4'(n), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("pz_done", 4'd15, 0, 0, 1);

    // Stop at out=9, no done afterwards, then a clean restart.
    applyStimulus(1, 0, 0, 4'd12, 4'd0, 0);
    for (int n = 1; n <= 9; n++) applyStimulus(0, 0, 0, 4'd12, 4'd0, 0);
    checkOutput("st_at9", 4'd9, 1, 0, 0);
    applyStimulus(0, 1, 0, 4'd12, 4'd0, 0);
    checkOutput("st_stop", 4'd0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(0, 0, 0, 4'd12, 4'd0, 0);
      checkOutput($sformatf("st_idle%0d", n), 4'd0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 4'd12, 4'd0, 0);
    checkOutput("st_restart", 4'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd12, 4'd0, 0);
    checkOutput("st_restart_n1", 4'd1, 1, 0, 0);
    applyStimulus(0, 1, 0, 4'd12, 4'd0, 0);

    // Start coincident with the terminal tick suppresses done and restarts.
    applyStimulus(1, 0, 0, 4'd2, 4'd0, 0);
    applyStimulus(0, 0, 0, 4'd2, 4'd0, 0);
    applyStimulus(0, 0, 0, 4'd2, 4'd0, 0);
    checkOutput("co_at2", 4'd2, 1, 0, 0);
    applyStimulus(1, 0, 0, 4'd2, 4'd0, 0);
    checkOutput("co_restart", 4'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd2, 4'd0, 0);
    checkOutput("co_n1", 4'd1, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd2, 4'd0, 0);
    checkOutput("co_n2", 4'd2, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd2, 4'd0, 0);
    checkOutput("co_done", 4'd2, 0, 0, 1);
    applyStimulus(0, 0, 0, 4'd2, 4'd0, 0);
    checkOutput("co_after", 4'd2, 0, 0, 0);

    // Reset mid-run at out=6; start is ignored while reset is low.
    applyStimulus(1, 0, 0, 4'd15, 4'd0, 0);
    for (int n = 1; n <= 6; n++) applyStimulus(0, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("rs_at6", 4'd6, 1, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("rs_low1", 4'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("rs_low2", 4'd0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 4'd15, 4'd0, 0);
    checkOutput("rs_idle", 4'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 4'd1, 4'd0, 0);
    checkOutput("rs_start", 4'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd1, 4'd0, 0);
    checkOutput("rs_n1", 4'd1, 1, 0, 0);
    applyStimulus(0, 0, 0, 4'd1, 4'd0, 0);
    checkOutput("rs_done", 4'd1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count16_sched.md
Name: count16_sched

Overview:
- Sequencing controller for the 4-bit free-running counter datapath.
- Adds command-driven start, stop and pause of counting.
- Adds a programmable terminal count, a clock prescaler, and one-shot or auto-reload operation.
- Signals completion with a single-cycle done pulse.
- Sits between a host or FSM issuing commands and logic that consumes the count value and the done event.

Parameters:
- WIDTH, 4: counter width; out wraps within 0..2^WIDTH-1.
- DIV_W, 4: prescaler divide-field width.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: single-cycle pulse; latches load_val, div and auto_reload, then begins counting from 0.
- stop, input, 1: single-cycle pulse; aborts the count and returns to IDLE.
- pause, input, 1: level; while high in RUN, the count freezes.
- load_val, input, WIDTH: terminal count value.
- div, input, DIV_W: prescaler; one count step every div+1 clocks.
- auto_reload, input, 1: 1 = periodic, 0 = one-shot.
- out, output, WIDTH: current count (registered).
- busy, output, 1: high when state is RUN or PAUSE.
- paused, output, 1: high when state is PAUSE.
- done, output, 1: registered, single-cycle pulse at terminal count.

Behaviour:
- Interface: single clock clk. Reset is synchronous and active-low, sampled on the rising edge of clk. While reset=0: state=IDLE, out=0, prescaler=0, done=0, busy=0, paused=0, and latched config is cleared (term_q=0, div_q=0, auto_q=0).
- Command priority per edge: reset > stop > start > pause.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start -> RUN. On that edge: out<=0, prescaler<=0, term_q<=load_val, div_q<=div, auto_q<=auto_reload. pause is ignored in IDLE.
  - RUN: prescaler increments each clock. When prescaler==div_q, a tick occurs and prescaler<=0.
    - Tick with out!=term_q: out<=out+1.
    - Tick with out==term_q: done<=1 for one cycle.
      - auto_q=1: out<=0 and stay in RUN.
      - auto_q=0: out holds term_q and state goes to IDLE.
    - pause=1 (with no stop or start on that edge): go to PAUSE. No tick is processed on that edge.
  - PAUSE: out and prescaler frozen. pause=0 -> RUN; counting resumes from the frozen prescaler value.
  - stop in RUN or PAUSE: go to IDLE, out<=0, prescaler<=0, no done.
  - start in RUN or PAUSE: restart exactly as from IDLE, with config relatched. start wins over a simultaneous terminal tick: no done is emitted and out<=0.
- done: low on every cycle except the one following a terminal tick. It is never asserted by stop, start or reset.
- Latency with div=0, start at edge k:
  - out=n after edge k+n, for n ≤ term_q.
  - done is high after edge k+term_q+1.
  - One-shot: busy falls after that same edge.
- load_val=0: out stays 0; done after edge k+1 (with div=0). In auto mode, done pulses every div_q+1 clocks.
- Prescaler: a count step occurs every (div_q+1) clocks. The period is fixed at start; changes to div mid-run are ignored.
- Arithmetic: out and prescaler are unsigned. out never exceeds term_q, so no overflow is possible. term_q=2^WIDTH-1 is legal.
- Reset mid-operation has the same effect as reset at power-up; no done is emitted.

Decomposition:
- Package count16_sched_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - default WIDTH and DIV_W constants.
- One sub-module, count16_ld: WIDTH-bit counter with synchronous active-low reset, clear, enable, and a terminal-compare flag.
- Prescaler and FSM stay in the top level.

Test Plan:
- Reset held low 2 cycles, then start with load_val=5, div=0, auto_reload=0 -> out steps 0,1,2,3,4,5 on consecutive edges; done high one cycle after out=5; busy falls; out holds 5.
- load_val=3, div=2, auto_reload=1 -> out advances every 3 clocks: 0,1,2,3,0,1...; done pulses every 12 clocks; busy stays 1.
- load_val=15, div=0, pause high for 4 cycles when out=7 -> out holds 7 and paused=1 for those cycles; counting resumes 8..15; done after out=15.
- Stop pulse when out=9 (load_val=12) -> next edge out=0, busy=0, done never asserted; later start restarts from 0.
- Start pulse coincident with the terminal tick (load_val=2, div=0, one-shot) -> no done, out=0, busy stays 1, and the new run completes normally.
- Reset driven low mid-run at out=6 -> next edge out=0, busy=0, paused=0, done=0; start is ignored while reset=0.
